// File: rtl/regfile_wb_scheduler_if.sv
// Writeback, register-file write port and issue-hazard signals of regfile_wb_scheduler.
// The slave modport is the scheduler side; master is the pipeline/requester side.
interface regfile_wb_scheduler_if #(
  parameter int XLEN    = 32,
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]      i_req_valid;
  logic [NUM_REQ*5-1:0]    i_req_rd;
  logic [NUM_REQ*XLEN-1:0] i_req_data;
  logic [NUM_REQ-1:0]      o_req_ready;

  logic [4:0]              o_rf_rd;
  logic [XLEN-1:0]         o_rf_din;
  logic                    o_rf_write;

  logic                    i_issue_valid;
  logic [4:0]              i_issue_rd;
  logic                    i_issue_rd_en;
  logic [4:0]              i_issue_rs1;
  logic [4:0]              i_issue_rs2;
  logic                    o_issue_stall;
  logic [31:0]             o_busy;

  modport slave (
    input  i_req_valid, i_req_rd, i_req_data,
    output o_req_ready,
    output o_rf_rd, o_rf_din, o_rf_write,
    input  i_issue_valid, i_issue_rd, i_issue_rd_en, i_issue_rs1, i_issue_rs2,
    output o_issue_stall, o_busy
  );

  modport master (
    output i_req_valid, i_req_rd, i_req_data,
    input  o_req_ready,
    input  o_rf_rd, o_rf_din, o_rf_write,
    output i_issue_valid, i_issue_rd, i_issue_rd_en, i_issue_rs1, i_issue_rs2,
    input  o_issue_stall, o_busy
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Round-robin share of the register-file write port plus a 32-entry busy scoreboard
// that stalls issue on RAW/WAW hazards.
module regfile_wb_scheduler #(
  parameter int XLEN    = 32,
  parameter int NUM_REQ = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  regfile_wb_scheduler_if.slave  bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [31:0]     busy_q, busy_d;
  logic            gnt_any;
  logic [PW-1:0]   gnt_idx;
  logic [4:0]      gnt_rd;
  logic [XLEN-1:0] gnt_data;
  logic [31:0]     clr_vec, set_vec, eff_busy;
  logic            stall;

  always_comb begin
    int            j;
    logic [PW-1:0] idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    j       = 0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      idx = PW'(j);
      if (!gnt_any && bus.i_req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign gnt_rd   = gnt_any ? bus.i_req_rd[gnt_idx*5 +: 5] : 5'd0;
  assign gnt_data = gnt_any ? bus.i_req_data[gnt_idx*XLEN +: XLEN] : '0;

  // A same-cycle writeback counts as ready: the register file forwards it to its read ports.
  assign clr_vec  = (gnt_any && gnt_rd != 5'd0) ? (32'd1 << gnt_rd) : 32'd0;
  assign eff_busy = busy_q & ~clr_vec;

  assign stall = bus.i_issue_valid &
                 (eff_busy[bus.i_issue_rs1] | eff_busy[bus.i_issue_rs2] |
                  (bus.i_issue_rd_en & eff_busy[bus.i_issue_rd]));

  assign set_vec = (bus.i_issue_valid && bus.i_issue_rd_en && !stall && bus.i_issue_rd != 5'd0)
                   ? (32'd1 << bus.i_issue_rd) : 32'd0;

  // The new producer wins over a retiring one on the same register.
  assign busy_d = (set_vec | eff_busy) & ~32'd1;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any) begin
      rr_ptr_d = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rr_ptr_q <= '0;
      busy_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.o_req_ready   = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign bus.o_rf_rd       = gnt_rd;
  assign bus.o_rf_din      = gnt_data;
  assign bus.o_rf_write    = gnt_any && (gnt_rd != 5'd0);
  assign bus.o_issue_stall = stall;
  assign bus.o_busy        = busy_q;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench for regfile_wb_scheduler: a spec-level model predicts each cycle's
// outputs into a queue, and an independent monitor pops and compares them.
module tb_regfile_wb_scheduler;
  localparam int XLEN    = 32;
  localparam int NUM_REQ = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_scheduler_if #(.XLEN(XLEN), .NUM_REQ(NUM_REQ)) bus ();

  regfile_wb_scheduler #(.XLEN(XLEN), .NUM_REQ(NUM_REQ)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [NUM_REQ-1:0] ready;
    logic [4:0]         rd;
    logic [XLEN-1:0]    din;
    logic               wr;
    logic               stall;
    logic [31:0]        busy;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // Requester and issue stimulus state
  bit              rv   [NUM_REQ];
  logic [4:0]      rrd  [NUM_REQ];
  logic [XLEN-1:0] rdat [NUM_REQ];
  bit              iv, iren;
  logic [4:0]      ird, irs1, irs2;

  // Reference model state
  int m_rr = 0;
  bit m_busy [32];
  bit armed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit eff_busy(input int r, input int clr_r);
    return (r != 0) && m_busy[r] && (r != clr_r);
  endfunction

  task automatic apply_inputs();
    for (int k = 0; k < NUM_REQ; k++) begin
      bus.i_req_valid[k]             = rv[k];
      bus.i_req_rd[5*k +: 5]         = rrd[k];
      bus.i_req_data[XLEN*k +: XLEN] = rdat[k];
    end
    bus.i_issue_valid = iv;
    bus.i_issue_rd    = ird;
    bus.i_issue_rd_en = iren;
    bus.i_issue_rs1   = irs1;
    bus.i_issue_rs2   = irs2;
  endtask

  // Called at a falling edge: drive, predict, advance the model, wait one cycle.
  task automatic step();
    exp_t e;
    int   g;
    int   clr_r;
    apply_inputs();
    #1;
    g = -1;
    for (int i = 0; i < NUM_REQ; i++) begin
      int k;
      k = (m_rr + i) % NUM_REQ;
      if (g < 0 && rv[k]) g = k;
    end
    e.ready = (g >= 0) ? NUM_REQ'(1 << g) : '0;
    e.rd    = (g >= 0) ? rrd[g] : 5'd0;
    e.din   = (g >= 0) ? rdat[g] : '0;
    e.wr    = (g >= 0) && (rrd[g] != 5'd0);
    clr_r   = e.wr ? int'(rrd[g]) : 0;
    e.stall = iv && (eff_busy(int'(irs1), clr_r) || eff_busy(int'(irs2), clr_r) ||
                     (iren && eff_busy(int'(ird), clr_r)));
    for (int r = 0; r < 32; r++) e.busy[r] = m_busy[r];
    if (armed) expq.push_back(e);

    if (!rst_n) begin
      m_rr = 0;
      for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
      armed = 1'b1;
    end else begin
      if (g >= 0) m_rr = (g + 1) % NUM_REQ;
      if (clr_r != 0) m_busy[clr_r] = 1'b0;
      if (iv && iren && !e.stall && ird != 5'd0) m_busy[ird] = 1'b1;
    end
    if (g >= 0) rv[g] = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int k = 0; k < NUM_REQ; k++) begin
      rv[k] = 1'b0; rrd[k] = 5'd0; rdat[k] = '0;
    end
    iv = 1'b0; iren = 1'b0; ird = 5'd0; irs1 = 5'd0; irs2 = 5'd0;
  endtask

  task automatic set_req(input int k, input logic [4:0] rd, input logic [XLEN-1:0] d);
    rv[k] = 1'b1; rrd[k] = rd; rdat[k] = d;
  endtask

  task automatic set_issue(input logic [4:0] rd, input bit en, input logic [4:0] s1, input logic [4:0] s2);
    iv = 1'b1; ird = rd; iren = en; irs1 = s1; irs2 = s2;
  endtask

  // Monitor: one prediction per cycle, sampled mid-low-phase.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("req_ready", 32'(bus.o_req_ready), 32'(e.ready));
        check("rf_rd",     32'(bus.o_rf_rd),     32'(e.rd));
        check("rf_din",    32'(bus.o_rf_din),    32'(e.din));
        check("rf_write",  32'(bus.o_rf_write),  32'(e.wr));
        check("issue_stall", 32'(bus.o_issue_stall), 32'(e.stall));
        check("busy",      bus.o_busy,           e.busy);
      end
    end
  end

  initial begin
    for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
    idle_all();
    apply_inputs();
    @(negedge clk);

    // Reset then idle
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step(); step();

    // Continuous contention from all requesters: grants rotate 0,1,2,0
    for (int c = 0; c < 4; c++) begin
      set_req(0, 5'd5, 32'hA);
      set_req(1, 5'd6, 32'hB);
      set_req(2, 5'd7, 32'hC);
      step();
    end
    idle_all();
    step();

    // RAW: produce r10, stall a consumer until requester 1 writes it back
    set_issue(5'd10, 1'b1, 5'd0, 5'd0);
    step();
    set_issue(5'd0, 1'b0, 5'd10, 5'd0);
    step(); step(); step();
    set_req(1, 5'd10, 32'h1234);
    step();
    idle_all();
    step();

    // WAW with same-cycle writeback: no stall, r3 stays busy
    set_issue(5'd3, 1'b1, 5'd0, 5'd0);
    step();
    idle_all();
    set_req(0, 5'd3, 32'h33);
    set_issue(5'd3, 1'b1, 5'd0, 5'd0);
    step();
    idle_all();
    step();

    // rd=0 writeback: acknowledged, no write
    set_req(2, 5'd0, 32'hFFFF);
    step();
    idle_all();
    step();

    // Reset mid-operation
    set_issue(5'd4, 1'b1, 5'd0, 5'd0);
    step();
    set_issue(5'd9, 1'b1, 5'd0, 5'd0);
    step();
    idle_all();
    set_req(1, 5'd12, 32'h12);
    set_req(2, 5'd13, 32'h13);
    step();
    idle_all();
    set_req(0, 5'd14, 32'h14);
    set_req(1, 5'd15, 32'h15);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle_all();
    set_req(0, 5'd14, 32'h14);
    set_req(1, 5'd15, 32'h15);
    step(); step();
    idle_all();
    step();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!rv[k] && ($urandom_range(0, 2) == 0)) begin
          set_req(k, 5'($urandom_range(0, 15)), $urandom);
        end
      end
      iv   = ($urandom_range(0, 1) == 1);
      iren = ($urandom_range(0, 1) == 1);
      ird  = 5'($urandom_range(0, 15));
      irs1 = 5'($urandom_range(0, 15));
      irs2 = 5'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < NUM_REQ; k++) rv[k] = 1'b0;
      end else begin
        step();
      end
    end

    idle_all();
    step(); step();
    #5;
    check("queue_drained", 32'(expq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Shares the single register-file write port between NUM_REQ writeback requesters (ALU, load unit, MUL/DIV) using round-robin arbitration.
- Tracks outstanding destination registers in a 32-entry busy scoreboard.
- Stalls issue on RAW and WAW hazards.
- Sits between the execute/memory writeback sources and the register file; its write-port outputs connect directly to the register file's rd, rd_din and reg_write inputs.

Parameters:
- XLEN, 32, data width of the register file.
- NUM_REQ, 3, number of writeback requesters (2..8).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_req_valid  in  NUM_REQ  per-requester writeback valid.
- i_req_rd  in  NUM_REQ*5  per-requester destination index; requester k occupies bits [5k+4:5k].
- i_req_data  in  NUM_REQ*XLEN  per-requester write data; requester k occupies bits [XLEN*k+XLEN-1:XLEN*k].
- o_req_ready  out  NUM_REQ  one-hot grant; the handshake completes when valid and ready are both high.
- o_rf_rd  out  5  register-file write index.
- o_rf_din  out  XLEN  register-file write data.
- o_rf_write  out  1  register-file write enable.
- i_issue_valid  in  1  instruction presented for issue.
- i_issue_rd  in  5  destination of the issuing instruction.
- i_issue_rd_en  in  1  issuing instruction writes rd through this scheduler.
- i_issue_rs1  in  5  source 1 index.
- i_issue_rs2  in  5  source 2 index.
- o_issue_stall  out  1  hazard; the issue stage must hold.
- o_busy  out  32  scoreboard busy vector, registered.

Behaviour:
- Reset:
  - Applied synchronously at the i_clk edge while i_rst_n=0.
  - Resets rr_ptr to 0 and o_busy to all zeros.
  - The combinational outputs are then 0, because no request is granted and no register is busy.
  - Reset mid-operation drops all pending requests and clears all busy bits; requesters must re-present after reset.
- Arbitration (combinational, zero latency):
  - Search the requesters starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first requester with valid=1 wins; o_req_ready is one-hot for that index, all zeros if none are valid.
  - On a grant to index k: rr_ptr <= (k+1) mod NUM_REQ at the clock edge. With no grant, rr_ptr holds.
- Requester rules:
  - Requesters hold valid, rd and data stable until granted.
  - o_req_ready may not depend on any other requester's ready.
- Write port:
  - o_rf_rd and o_rf_din mux from the granted requester, and are 0 when there is no grant.
  - o_rf_write = grant AND granted rd != 0. An rd=0 request is still granted and acknowledged, but no write is issued.
- Scoreboard:
  - clr[r] is high when a grant occurs with rd=r, r != 0.
  - set[r] is high when i_issue_valid AND i_issue_rd_en AND !o_issue_stall AND i_issue_rd=r, r != 0.
  - Next state: busy[r] <= set[r] OR (busy[r] AND !clr[r]). A simultaneous set and clear on the same r leaves busy=1, because the new producer wins.
  - busy[0] is always 0.
- Stall:
  - eff_busy[r] = busy[r] AND !clr[r]. A same-cycle writeback counts as ready because the register file forwards write data to its read ports.
  - o_issue_stall = i_issue_valid AND (eff_busy[rs1] OR eff_busy[rs2] OR (i_issue_rd_en AND eff_busy[rd])).
  - Index 0 never causes a stall.
- Error case: a writeback to an rd whose busy bit is 0 is legal (e.g. a fixed-latency ALU result not tracked by the scoreboard). It is written normally and busy stays 0.
- Throughput: one write per cycle. Each requester waits at most NUM_REQ-1 cycles while it continuously asserts valid.

Test Plan:
- Reset then idle -> o_busy=0, o_rf_write=0, o_req_ready=0, o_issue_stall=0.
- All three requesters valid continuously (rd=5,6,7; data 0xA,0xB,0xC) from rr_ptr=0 -> grants 0,1,2,0 on consecutive cycles; o_rf_rd=5,6,7,5.
- Issue rd=10 (rd_en=1), then issue with rs1=10 while requester 1 is absent -> busy[10]=1 and stall=1 every cycle. Requester 1 then writes rd=10, data 0x1234 -> in that same cycle stall=0, o_rf_write=1, o_rf_din=0x1234, and busy[10]=0 on the next cycle.
- Same cycle: requester 0 writes rd=3 while issue rd=3, rs1=0, rs2=0 -> WAW has no stall because of the same-cycle clear; busy[3] stays 1 afterwards.
- Requester 2 valid with rd=0, data 0xFFFF -> o_req_ready[2]=1, o_rf_write=0, o_busy unchanged.
- Busy bits 4 and 9 set and requesters 0 and 1 valid, then i_rst_n=0 for 1 cycle -> o_busy=0 and rr_ptr=0; after reset, requester 0 is granted first.
